qout_fifo_capture: RTL
======================

// Module: qout_fifo_capture
// PURPOSE
//  Parametrised successor of the 6-bit conversion-result output register.
//  Captures a W-bit conversion result on a result strobe, but only after a sample (arm) pulse.
//  Optionally inverts selected bits, then queues the results in a DEPTH-entry FIFO.
//  Results are drained through a valid/ready port. Sits between the converter core and the readout/Wishbone logic.
// PARAMETERS
//  W         6     result width in bits
//  DEPTH     4     FIFO entries; power of 2, >=2
//  INV_MASK  6'b1  per-bit XOR applied at capture (bit0 inverted by default)
// PORTS
//  clk        in   1           single system clock, rising edge
//  rst        in   1           asynchronous, active-low reset (0 = reset)
//  sample     in   1           sync pulse: start of conversion; arms capture
//  rs         in   1           sync pulse: result strobe; r is valid this cycle
//  r          in   W           raw conversion result
//  clear      in   1           sync: flush FIFO, clear sticky flags
//  q          out  W           FIFO head (show-ahead); 0 when empty
//  q_valid    out  1           FIFO not empty
//  q_ready    in   1           consumer accepts q when q_valid & q_ready
//  level      out  clog2(DEPTH)+1  current occupancy
//  armed      out  1           capture armed, awaiting rs
//  overflow   out  1           sticky: a strobed result was dropped (FIFO full)
//  stray      out  1           sticky: rs arrived while not armed
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, all pointers 0, q=0, q_valid=0, level=0,
//    armed=0, overflow=0, stray=0. Reset mid-operation discards everything.
//  State machine (2 states, registered):
//    IDLE  -sample-> ARMED.  ARMED -rs & !sample-> IDLE (capture attempted).
//    ARMED -sample-> ARMED (re-arm, no capture).
//  Simultaneous sample & rs: sample wins; rs is ignored; stray is not set.
//  Capture: on rs in ARMED, push (r ^ INV_MASK) in the same cycle.
//  Latency: pushed into empty FIFO at edge t -> q/q_valid visible after edge t (1 clk).
//  rs in IDLE (without sample): no push; stray<=1.
//  Push while full: push accepted only if a pop happens the same cycle; otherwise the
//    word is dropped, overflow<=1, and FIFO contents are unchanged.
//  Pop: q_valid & q_ready -> head advances; popping when empty is a no-op.
//  Simultaneous push & pop (non-full, non-empty): level unchanged.
//  Push & pop on an empty FIFO: the pop is a no-op (q_valid was 0); level becomes 1.
//  clear: empties the FIFO and clears overflow/stray. It does not change armed.
//    clear has priority over push/pop in that cycle.
//  Pointers: log2(DEPTH) bits, wrap modulo DEPTH. level = wptr - rptr using extra MSB.
//  q is driven combinationally from the storage at rptr, gated to 0 when empty.
// STRUCTURE
//  qout_pkg: typedef enum {IDLE, ARMED} qout_state_t; localparam QOUT_W_DEFAULT=6.
//  Sub-module qout_sync_fifo #(W,DEPTH): storage, pointers, level, full/empty, show-ahead q.
//  Top: arm FSM, INV_MASK XOR, sticky flags, push/pop gating.
// TESTING
//  1. Reset while FIFO holds 2 words -> all outputs 0 immediately (async), without waiting for clk.
//  2. sample, then rs with r=6'h2A -> next cycle q=6'h2B, q_valid=1, level=1, armed=0.
//  3. rs with no prior sample -> no push, stray=1, level stays 0.
//     Then clear -> stray=0.
//  4. 5 arm+strobe pairs (r=1..5), q_ready=0, DEPTH=4 -> level=4, overflow=1.
//     Head q=0, i.e. 1^1. Drain yields 0,3,2,5 in order.
//  5. Full FIFO with q_ready=1 on the same cycle as arm+rs -> push accepted, overflow stays 0, level stays 4.
//  6. sample and rs in the same cycle -> no push, armed=1.
//     The next rs with r=6'h10 -> q=6'h11.

Source files
------------

// File: rtl/qout_pkg.sv
// Shared types and defaults for the conversion-result capture FIFO.
package qout_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } qout_state_t;

    localparam int QOUT_W_DEFAULT = 6;

endpackage

// File: rtl/qout_fifo_capture_if.sv
// Capture/readout bundle between the converter core, the capture block and the readout logic.
interface qout_fifo_capture_if #(
    parameter int W     = 6,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          sample;
    logic          rs;
    logic [W-1:0]  r;
    logic          clear;
    logic [W-1:0]  q;
    logic          q_valid;
    logic          q_ready;
    logic [LW-1:0] level;
    logic          armed;
    logic          overflow;
    logic          stray;

    // Driver side: converter core plus readout consumer.
    modport master (
        output sample, rs, r, clear, q_ready,
        input  q, q_valid, level, armed, overflow, stray
    );

    // Capture block side.
    modport slave (
        input  sample, rs, r, clear, q_ready,
        output q, q_valid, level, armed, overflow, stray
    );
endinterface

// File: rtl/qout_sync_fifo.sv
// Show-ahead synchronous FIFO. Pointers carry one extra MSB so full and empty differ.
module qout_sync_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             q_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         do_push, do_pop;

    assign level_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (level_o == (AW+1)'(DEPTH));

    // Popping an empty FIFO does nothing; a full FIFO takes a push only alongside a pop.
    assign do_pop  = pop_i & ~empty_o & ~clear_i;
    assign do_push = push_i & (~full_o | do_pop) & ~clear_i;

    assign q_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    // Pointer next state; clear snaps both pointers back to zero.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: the head is gated to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/qout_fifo_capture.sv
// Arm-then-strobe capture of conversion results into a small readout FIFO.
module qout_fifo_capture
    import qout_pkg::*;
#(
    parameter int           W        = QOUT_W_DEFAULT,
    parameter int           DEPTH    = 4,
    parameter logic [W-1:0] INV_MASK = {{(W-1){1'b0}}, 1'b1}
) (
    input  logic                clk,
    input  logic                rst,
    qout_fifo_capture_if.slave  bus
);
    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_ARMED = ARMED;

    logic [0:0] state_q, state_d;
    logic       overflow_q, overflow_d;
    logic       stray_q, stray_d;
    logic       push_req, pop_req, drop, stray_ev, full, empty;

    // sample beats rs in the same cycle, so rs only counts without sample.
    assign push_req = bus.rs & ~bus.sample & (state_q == S_ARMED);
    assign stray_ev = bus.rs & ~bus.sample & (state_q == S_IDLE);
    assign pop_req  = bus.q_valid & bus.q_ready;
    assign drop     = push_req & full & ~pop_req;

    // Arm FSM: sample (re)arms, an accepted strobe disarms.
    always_comb begin
        state_d = state_q;
        if (bus.sample)    state_d = S_ARMED;
        else if (push_req) state_d = S_IDLE;
    end

    // Sticky error flags; clear wins over any new event.
    always_comb begin
        overflow_d = overflow_q;
        stray_d    = stray_q;
        if (bus.clear) begin
            overflow_d = 1'b0;
            stray_d    = 1'b0;
        end else begin
            if (drop)     overflow_d = 1'b1;
            if (stray_ev) stray_d    = 1'b1;
        end
    end

    // State and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            overflow_q <= 1'b0;
            stray_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            stray_q    <= stray_d;
        end
    end

    qout_sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (bus.clear),
        .push_i  (push_req),
        .data_i  (bus.r ^ INV_MASK),
        .pop_i   (pop_req),
        .q_o     (bus.q),
        .level_o (bus.level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.q_valid  = ~empty;
    assign bus.armed    = (state_q == S_ARMED);
    assign bus.overflow = overflow_q;
    assign bus.stray    = stray_q;
endmodule
